cell_histogram: RTL and testbench
=================================

# cell_histogram

Consumer of the gradient binning stream: accepts one (magnitude, bin) pair per gradient pixel over a valid/ready handshake and accumulates magnitudes into per-cell orientation histograms (CELL_SIZE × CELL_SIZE pixels, NUM_BINS bins). It emits one complete histogram per cell in raster order of cells, using a line memory holding one partial histogram per cell column. It sits directly downstream of the binning stage and feeds block normalisation.

## Interface

- DATA_WIDTH, 8, magnitude width.
- IMAGE_WIDTH, 640, gradient pixels per row arriving on the input. Must be a multiple of CELL_SIZE; elaboration error otherwise.
- IMAGE_HEIGHT, 480, gradient rows per frame. Must be a multiple of CELL_SIZE; elaboration error otherwise.
- CELL_SIZE, 8, cell edge in pixels, power of two, ≥2.
- NUM_BINS, 9, histogram bins.
- BIN_WIDTH, DATA_WIDTH + 2·log2(CELL_SIZE), accumulator width per bin (14 at defaults); never overflows.

Ports:

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- bin_valid  in  1  input pair valid.
- bin_ready  out  1  input pair accepted when bin_valid && bin_ready.
- magnitude  in  DATA_WIDTH  gradient magnitude.
- bin  in  4  orientation bin index, 0..NUM_BINS-1.
- hist_valid  out  1  histogram output valid.
- hist_ready  in  1  downstream accepts histogram.
- hist  out  NUM_BINS·BIN_WIDTH  bin k at bits [k·BIN_WIDTH +: BIN_WIDTH].
- cell_x  out  clog2(IMAGE_WIDTH/CELL_SIZE)  cell column of hist.
- cell_y  out  clog2(IMAGE_HEIGHT/CELL_SIZE)  cell row of hist.
- frame_done  out  1  one-cycle pulse with the acceptance of the frame's last histogram.

## Operation

- Counters px (0..IMAGE_WIDTH-1), py (0..IMAGE_HEIGHT-1) advance on each accepted pair; px wraps to 0 and increments py; both wrap to 0 after the last pixel of the frame.
- Span = CELL_SIZE consecutive pixels of one row inside one cell. Local register bank (NUM_BINS × BIN_WIDTH) accumulates the span; cleared at span start.
- Contribution: magnitude zero-extended to BIN_WIDTH, added to bin[bin]. bin ≥ NUM_BINS: contributes nothing; pixel still counted.
- At span start (px mod CELL_SIZE == 0), issue line-memory read at px/CELL_SIZE.
- At span end (px mod CELL_SIZE == CELL_SIZE-1), sum = base + local + current contribution, where base = 0 if py mod CELL_SIZE == 0, else the read data.
  - py mod CELL_SIZE != CELL_SIZE-1: write sum to memory at px/CELL_SIZE.
  - Otherwise: load sum into hist, set cell_x = px/CELL_SIZE, cell_y = py/CELL_SIZE, assert hist_valid. No memory write.
- Memory is never cleared; the first-row base rule makes stale contents irrelevant.
- State machine: ACCUM (hist_valid=0) → EMIT on last-row span end. EMIT → ACCUM on hist_ready without a new emission that same cycle; EMIT stays EMIT if hist_ready and a new span end coincide (hist reloaded).
- bin_ready = !hist_valid || hist_ready.

## Timing

- Reset: px, py, local bank, hist, cell_x, cell_y = 0; hist_valid = 0; frame_done = 0; state ACCUM. bin_ready = 1 after reset.
- Reset mid-frame discards all partial histograms; next accepted pair is pixel (0,0).
- Memory read latency 1 cycle, registered, held until next read; CELL_SIZE ≥ 2 guarantees data is ready by span end.
- Latency: hist_valid rises the cycle after acceptance of the cell's last pixel.
- hist, cell_x, cell_y stable while hist_valid && !hist_ready.
- Throughput: one pair per cycle while hist_ready is high; no bubbles at span, row or frame boundaries.
- frame_done: asserted the cycle after hist for cell (last, last) is accepted.

## Structure

- Shared package hog_pkg holds NUM_BINS, the bin index width (4), and the BIN_WIDTH derivation function; binning and block normalisation use the same constants.
- One sub-module: hist_line_ram. It is a simple dual-port RAM with depth IMAGE_WIDTH/CELL_SIZE, width NUM_BINS·BIN_WIDTH, registered read, and a write-first-irrelevant port (read and write addresses never collide in the same cycle).

## Test plan

- Reset: hold rst low, then release → hist_valid=0, bin_ready=1, frame_done=0.
- 16×16 frame, magnitude=1, bin=3 everywhere → four histograms in order (0,0),(1,0),(0,1),(1,1), each bin3=64 and others 0; frame_done pulses once after the fourth.
- Worst case: magnitude=255, bin=8 for a full cell → bin8=16320, no overflow in 14 bits.
- Backpressure: hold hist_ready low at the first emission → bin_ready=0 and hist stable. Release → one transfer, and input resumes the same cycle.
- bin=12 on every pixel in cell (0,0) with magnitude=200 → all bins 0, and cell order unaffected.
- Assert reset at pixel (5,3) of frame 1, then drive a fresh 16×16 frame → histograms match the golden model with no residue from before reset.

Source files
------------

// File: rtl/hog_pkg.sv
// hog_pkg: constants and helpers shared by the HOG binning, cell histogram and normalisation stages.
package hog_pkg;
   localparam int NUM_BINS  = 9;
   localparam int BIN_IDX_W = 4;
   typedef enum logic {ACCUM, EMIT} hist_state_t;
   function automatic int bin_width(input int data_width, input int cell_size);
      return data_width + 2 * $clog2(cell_size);
   endfunction
endpackage

// File: rtl/hist_line_ram.sv
// hist_line_ram: simple dual-port RAM holding one partial histogram per cell column, registered read.
module hist_line_ram #(
   parameter int DEPTH = 80,
   parameter int WIDTH = 126,
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/cell_histogram.sv
// cell_histogram: accumulates (magnitude, bin) pairs into per-cell orientation histograms,
// emitted in raster order of cells; a line memory carries partial sums between pixel rows.
module cell_histogram #(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int CELL_SIZE    = 8,
   parameter int NUM_BINS     = hog_pkg::NUM_BINS,
   parameter int BIN_WIDTH    = hog_pkg::bin_width(DATA_WIDTH, CELL_SIZE),
   localparam int CXW = $clog2(IMAGE_WIDTH / CELL_SIZE),
   localparam int CYW = $clog2(IMAGE_HEIGHT / CELL_SIZE),
   localparam int BIW = hog_pkg::BIN_IDX_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          bin_valid,
   output logic                          bin_ready,
   input  logic [DATA_WIDTH-1:0]         magnitude,
   input  logic [BIW-1:0]                bin,
   output logic                          hist_valid,
   input  logic                          hist_ready,
   output logic [NUM_BINS*BIN_WIDTH-1:0] hist,
   output logic [CXW-1:0]                cell_x,
   output logic [CYW-1:0]                cell_y,
   output logic                          frame_done
);
   localparam int LW  = $clog2(CELL_SIZE);
   localparam int PXW = $clog2(IMAGE_WIDTH);
   localparam int PYW = $clog2(IMAGE_HEIGHT);
   localparam int NCX = IMAGE_WIDTH / CELL_SIZE;
   localparam int NCY = IMAGE_HEIGHT / CELL_SIZE;

   if (IMAGE_WIDTH % CELL_SIZE != 0 || IMAGE_HEIGHT % CELL_SIZE != 0) begin : g_bad_dim
      $error("cell_histogram: image dimensions must be multiples of CELL_SIZE");
   end
   if (CELL_SIZE < 2 || (CELL_SIZE & (CELL_SIZE - 1)) != 0) begin : g_bad_cell
      $error("cell_histogram: CELL_SIZE must be a power of two >= 2");
   end

   typedef logic [NUM_BINS-1:0][BIN_WIDTH-1:0] bank_t;

   hog_pkg::hist_state_t state;
   logic [PXW-1:0] px;
   logic [PYW-1:0] py;
   bank_t lbank, contrib, sum, rd_data;
   logic accept, span_start, span_end, first_row, last_row, emit;

   assign bin_ready  = !hist_valid || hist_ready;
   assign accept     = bin_valid && bin_ready;
   assign span_start = px[LW-1:0] == '0;
   assign span_end   = &px[LW-1:0];
   assign first_row  = py[LW-1:0] == '0;
   assign last_row   = &py[LW-1:0];
   assign emit       = accept && span_end && last_row;

   // Out-of-range bin indices match no k and therefore contribute nothing.
   always_comb begin
      contrib = '0;
      sum     = '0;
      for (int k = 0; k < NUM_BINS; k++) begin
         contrib[k] = (bin == BIW'(k)) ? BIN_WIDTH'(magnitude) : '0;
         sum[k]     = (first_row ? '0 : rd_data[k]) + lbank[k] + contrib[k];
      end
   end

   hist_line_ram #(.DEPTH(NCX), .WIDTH(NUM_BINS * BIN_WIDTH)) u_line_ram (
      .clk     (clk),
      .wr_en   (accept && span_end && !last_row),
      .wr_addr (px[PXW-1:LW]),
      .wr_data (sum),
      .rd_en   (accept && span_start),
      .rd_addr (px[PXW-1:LW]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= hog_pkg::ACCUM;
         px         <= '0;
         py         <= '0;
         lbank      <= '0;
         hist       <= '0;
         cell_x     <= '0;
         cell_y     <= '0;
         hist_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= hist_valid && hist_ready && cell_x == CXW'(NCX - 1) && cell_y == CYW'(NCY - 1);
         if (accept) begin
            px <= (px == PXW'(IMAGE_WIDTH - 1)) ? '0 : px + 1'b1;
            if (px == PXW'(IMAGE_WIDTH - 1)) py <= (py == PYW'(IMAGE_HEIGHT - 1)) ? '0 : py + 1'b1;
            for (int k = 0; k < NUM_BINS; k++) lbank[k] <= (span_start ? '0 : lbank[k]) + contrib[k];
         end
         // A new emission takes priority so back-to-back cells reload hist without a bubble.
         if (emit) begin
            state      <= hog_pkg::EMIT;
            hist       <= sum;
            cell_x     <= px[PXW-1:LW];
            cell_y     <= py[PYW-1:LW];
            hist_valid <= 1'b1;
         end else if (state == hog_pkg::EMIT && hist_ready) begin
            state      <= hog_pkg::ACCUM;
            hist_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cell_histogram.sv
// tb_cell_histogram: directed frames on a 16x16 image against a per-cell golden model and scoreboard.
module tb_cell_histogram;
   localparam int W = 16, H = 16, CS = 8, BW = 14, NB = 9;

   logic clk = 0, rst = 0;
   logic bin_valid = 0, hist_ready = 1;
   logic [7:0] magnitude = '0;
   logic [3:0] bin = '0;
   logic bin_ready, hist_valid, frame_done;
   logic [NB*BW-1:0] hist;
   logic [0:0] cell_x, cell_y;

   cell_histogram #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CELL_SIZE(CS)) dut (
      .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(bin_ready),
      .magnitude(magnitude), .bin(bin), .hist_valid(hist_valid), .hist_ready(hist_ready),
      .hist(hist), .cell_x(cell_x), .cell_y(cell_y), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:0]       cx;
      logic [0:0]       cy;
      logic [NB*BW-1:0] h;
   } exp_t;

   exp_t q[$];
   int gold[2][2][NB];
   int bx = 0, by = 0;
   int tests = 0, fails = 0, fd_count = 0;
   logic fd_exp = 0;
   logic [NB*BW-1:0] last00 = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) for (int k = 0; k < NB; k++) gold[y][x][k] = 0;
      bx = 0;
      by = 0;
   endtask

   task automatic model_accept(input logic [7:0] m, input logic [3:0] b);
      exp_t e;
      if (b < NB) gold[by/CS][bx/CS][b] += int'(m);
      if (bx % CS == CS-1 && by % CS == CS-1) begin
         e.cx = 1'(bx / CS);
         e.cy = 1'(by / CS);
         e.h  = '0;
         for (int k = 0; k < NB; k++) begin
            e.h[k*BW +: BW] = BW'(gold[by/CS][bx/CS][k]);
            gold[by/CS][bx/CS][k] = 0;
         end
         q.push_back(e);
      end
      bx = (bx == W-1) ? 0 : bx + 1;
      if (bx == 0) by = (by == H-1) ? 0 : by + 1;
   endtask

   task automatic send(input logic [7:0] m, input logic [3:0] b);
      int n = 0;
      magnitude = m;
      bin = b;
      bin_valid = 1;
      #1;
      while (!bin_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bin_ready) chk("accept_timeout", bin_ready, 1);
      @(negedge clk);
      model_accept(m, b);
   endtask

   task automatic pick(input int mode, output logic [7:0] m, output logic [3:0] b);
      logic c00 = bx < CS && by < CS;
      m = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      if (mode == 0) begin m = 8'd1; b = 4'd3; end
      if (mode == 1 && c00) begin m = 8'd255; b = 4'd8; end
      if (mode == 2 && c00) begin m = 8'd200; b = 4'd12; end
   endtask

   task automatic run_frame(input int mode, input int npix, input bit stall);
      logic [7:0] m;
      logic [3:0] b;
      logic [NB*BW-1:0] uni = '0;
      uni[3*BW +: BW] = BW'(64);
      for (int i = 0; i < npix; i++) begin
         pick(mode, m, b);
         if (stall && i == 120) begin
            magnitude = m;
            bin = b;
            bin_valid = 1;
            #1;
            chk("stall_hist_valid", hist_valid, 1);
            chk("stall_bin_ready", bin_ready, 0);
            chk("stall_hist", hist, uni);
            repeat (3) @(negedge clk);
            #1;
            chk("stall_hist_stable", hist, uni);
            chk("stall_cell_x", cell_x, 0);
            chk("stall_cell_y", cell_y, 0);
            chk("stall_still_blocked", bin_ready, 0);
            hist_ready = 1;
            #1;
            chk("release_bin_ready", bin_ready, 1);
         end
         send(m, b);
         if (stall && i == 120) chk("release_hist_valid_drop", hist_valid, 0);
      end
      bin_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst) fd_exp = 0;
      else begin
         if (fd_exp || frame_done) chk("frame_done", frame_done, fd_exp);
         if (frame_done) fd_count++;
         fd_exp = 0;
         if (hist_valid && hist_ready) begin
            if (q.size() == 0) chk("unexpected_hist", hist_valid, 0);
            else begin
               e = q.pop_front();
               chk("hist_cell_x", cell_x, e.cx);
               chk("hist_cell_y", cell_y, e.cy);
               chk("hist_bins", hist, e.h);
               if (e.cx == 0 && e.cy == 0) last00 = hist;
               fd_exp = (e.cx == 1 && e.cy == 1);
            end
         end
      end
   end

   initial begin
      model_clear();
      repeat (3) @(negedge clk);
      #1;
      chk("reset_hist_valid", hist_valid, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_hist", hist, 0);
      rst = 1;
      @(negedge clk);
      #1;
      chk("post_reset_bin_ready", bin_ready, 1);
      chk("post_reset_hist_valid", hist_valid, 0);
      @(negedge clk);

      hist_ready = 0;
      run_frame(0, W*H, 1);
      drain();
      chk("frame1_done_count", fd_count, 1);

      run_frame(1, W*H, 0);
      drain();
      chk("worst_bin8", last00[8*BW +: BW], 14'd16320);
      chk("worst_other_bins", last00[8*BW-1:0], 0);
      chk("frame2_done_count", fd_count, 2);

      run_frame(2, W*H, 0);
      drain();
      chk("ignored_bins_zero", last00, 0);
      chk("frame3_done_count", fd_count, 3);

      run_frame(3, 3*W + 6, 0);
      rst = 0;
      q.delete();
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("midreset_hist_valid", hist_valid, 0);
      chk("midreset_bin_ready", bin_ready, 1);
      rst = 1;
      @(negedge clk);
      run_frame(3, W*H, 0);
      drain();
      chk("frame5_done_count", fd_count, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
